sha256_block_ctrl: RTL
======================

// Module: sha256_block_ctrl
// PURPOSE
//  - Sequences one SHA-256 compression of a 512-bit block, one round per clock.
//  - Drives the round datapath, including its fixed right-rotators (ROTR 2/6/11/13/22/25, sigma 7/17/18/19).
//  - Owns the 16-word message-schedule window and the chaining value H0..H7.
//  - Sits between the block/nonce feeder (upstream) and the target comparator (downstream) in the miner.
// PARAMETERS
//  - ROUNDS  64  rounds per block. Must be 16..64; values below 64 are for reduced-round debug only.
//  - CNT_W   32  width of the block counter. Present only with SHA256_BLKCNT_EN.
// PORTS
//  - clk         in   1    single clock, rising edge
//  - rst         in   1    reset, asynchronous, active-high
//  - in_valid    in   1    in_block/in_init valid
//  - in_ready    out  1    controller can accept a block
//  - in_block    in   512  message block; word0 = [511:480], big-endian
//  - in_init     in   1    1: start from the standard IV; 0: chain from the current H
//  - out_valid   out  1    out_digest valid
//  - out_ready   in   1    downstream accepts the digest
//  - out_digest  out  256  H0..H7; H0 = [255:224]
//  - busy        out  1    high in any state other than IDLE
//  - blk_count   out  CNT_W  completed-block count (SHA256_BLKCNT_EN only)
// BEHAVIOUR
//  - Reset values: in_ready=0 during reset and 1 in IDLE after reset; out_valid=0; out_digest=0; busy=0; blk_count=0.
//    The H registers reset to the IV, so in_init=0 immediately after reset is equivalent to in_init=1.
//  - FSM states: IDLE, ROUND, FINAL, DONE.
//  - IDLE: in_ready=1.
//    - On in_valid&in_ready (cycle T): load W window from in_block.
//    - Load a..h from the IV (in_init=1) or from H (in_init=0); if in_init=1, H is also loaded with the IV.
//    - rcnt=0; next state ROUND.
//  - ROUND: one round per cycle using K[rcnt] and W[rcnt], where
//    W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] for t>=16.
//    - The window shifts by one word each cycle.
//    - On rcnt==ROUNDS-1, go to FINAL; otherwise rcnt++.
//  - FINAL: H[i] <= H[i] + {a..h}[i], all sums mod 2^32 with carries dropped.
//    - out_digest <= new H; out_valid <= 1; go to DONE.
//  - DONE: out_valid=1, first high at cycle T+ROUNDS+2, i.e. T+66 at default.
//    - out_digest is held stable until out_valid&out_ready.
//    - On handshake: out_valid <= 0, go to IDLE. in_ready rises the following cycle.
//  - Throughput: one block per ROUNDS+3 cycles when out_ready is tied high.
//  - in_ready=0 in ROUND/FINAL/DONE; in_valid is ignored there and in_block may change freely.
//  - rst mid-block: the operation is aborted, the partial state is discarded, H returns to the IV, and the FSM goes to IDLE.
//    No out_valid is produced for the aborted block.
//  - rcnt is a 6-bit counter with no wrap; it is cleared on load.
// CONFIGURATION
//  - SHA256_BLKCNT_EN defined:
//    - blk_count increments by 1 on each digest handshake (out_valid&out_ready).
//    - It wraps modulo 2^CNT_W and clears on rst.
//  - SHA256_BLKCNT_EN undefined: the blk_count port and the counter do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package sha256_pkg holds:
//    - K[0:63] round constants and the IV[0:7] constants;
//    - the FSM state typedef (IDLE/ROUND/FINAL/DONE);
//    - functions ROTR/SHR, Sigma0/Sigma1/sigma0/sigma1, Ch and Maj.
//  - One sub-module, sha256_round: combinational single round, (a..h, K, W) -> (a'..h').
//    It is instantiated once; the controller owns all registers and the schedule window.
// TESTING
//  1. Single block "abc", padded 61626380 0..0 00000018, in_init=1, out_ready=1:
//     -> out_digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad at T+66.
//  2. Empty message, block 80000000 0..0 00000000, in_init=1:
//     -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
//  3. Two blocks of the 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" message:
//     first block in_init=1, second in_init=0
//     -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  4. Backpressure: hold out_ready=0 for 20 cycles after out_valid
//     -> digest stable, in_ready=0 throughout, in_valid pulses ignored; accept one cycle after out_ready=1.
//  5. Assert rst at round 30 of an "abc" block, then send "abc" again with in_init=0
//     -> no out_valid from the aborted block; the second block produces the ba7816bf... digest (H back at IV).
//  6. With SHA256_BLKCNT_EN: 3 blocks back-to-back -> blk_count 0->1->2->3, each step on a digest handshake;
//     without the macro, the build has no blk_count port.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, FSM state type and bit-level helper functions
//
// Contents:
//   state_t                      controller states IDLE/ROUND/FINAL/DONE
//   K[0:63]                      round constants
//   IV[0:7], IV_WORDS            initial hash value (array form and packed H0..H7 form)
//   rotr/shr                     32-bit rotate-right / shift-right
//   big_sigma0/1, small_sigma0/1 SHA-256 mixing functions
//   ch/maj                       choose and majority
package sha256_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // H0 occupies the top word, matching the out_digest layout.
  localparam logic [255:0] IV_WORDS = {
    IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]
  };

  // Always called with constant shift amounts, so these reduce to wiring.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] shr(input logic [31:0] x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - combinational single SHA-256 round
//
// Ports:
//   st_in   in  256  working variables a..h, a = [255:224]
//   k       in  32   round constant K[t]
//   w       in  32   schedule word W[t]
//   st_out  out 256  updated working variables a'..h', same layout
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] st_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] st_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = st_in;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_block_ctrl.sv
// rtl/sha256_block_ctrl.sv - sequences one SHA-256 block compression, one round per clock
//
// Optional feature: define SHA256_BLKCNT_EN to add the blk_count port and counter.
//
// Parameters:
//   ROUNDS      rounds per block (16..64; below 64 only for reduced-round debug)
//   CNT_W       block counter width (SHA256_BLKCNT_EN only)
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset
//   in_valid    in   1      in_block/in_init valid
//   in_ready    out  1      controller can accept a block (IDLE, not in reset)
//   in_block    in   512    message block, word0 = [511:480]
//   in_init     in   1      1: start from IV, 0: chain from current H
//   out_valid   out  1      out_digest valid
//   out_ready   in   1      downstream accepts the digest
//   out_digest  out  256    H0..H7, H0 = [255:224]
//   busy        out  1      controller not in IDLE
//   blk_count   out  CNT_W  completed-block count (SHA256_BLKCNT_EN only)
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
`ifdef SHA256_BLKCNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_init,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
`ifdef SHA256_BLKCNT_EN
  ,
  output logic [CNT_W-1:0] blk_count
`endif
);

  localparam logic [5:0] LAST_RCNT = 6'(ROUNDS - 1);

  state_t state, state_nxt;

  logic         load_en, round_en, final_en, done_hs;
  logic [5:0]   rcnt;
  logic [31:0]  w_win [0:15];
  logic [31:0]  w_new;
  logic [255:0] work;
  logic [255:0] round_out;
  logic [255:0] h_reg;
  logic [255:0] h_sum;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    round_en  = 1'b0;
    final_en  = 1'b0;
    done_hs   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          load_en   = 1'b1;
          state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        round_en = 1'b1;
        if (rcnt == LAST_RCNT) begin
          state_nxt = S_FINAL;
        end
      end
      S_FINAL: begin
        final_en  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          done_hs   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The state register sits in IDLE while reset is held, so reset is
  // folded in here to keep in_ready low during reset.
  assign in_ready = (state == S_IDLE) && !rst;
  assign busy     = (state != S_IDLE);

  // ---------------------------------------------------------- datapath
  // w_win[0] is always W[rcnt]; the word appended at the tail is W[rcnt+16].
  assign w_new = small_sigma1(w_win[14]) + w_win[9] + small_sigma0(w_win[1]) + w_win[0];

  sha256_round u_round (
    .st_in  (work),
    .k      (K[rcnt]),
    .w      (w_win[0]),
    .st_out (round_out)
  );

  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[255-32*i -: 32] = h_reg[255-32*i -: 32] + work[255-32*i -: 32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt       <= '0;
      work       <= '0;
      h_reg      <= IV_WORDS;
      out_valid  <= 1'b0;
      out_digest <= '0;
      for (int i = 0; i < 16; i++) begin
        w_win[i] <= '0;
      end
    end else begin
      if (load_en) begin
        for (int i = 0; i < 16; i++) begin
          w_win[i] <= in_block[511-32*i -: 32];
        end
        work <= in_init ? IV_WORDS : h_reg;
        if (in_init) begin
          h_reg <= IV_WORDS;
        end
        rcnt <= '0;
      end
      if (round_en) begin
        work <= round_out;
        for (int i = 0; i < 15; i++) begin
          w_win[i] <= w_win[i+1];
        end
        w_win[15] <= w_new;
        if (rcnt != LAST_RCNT) begin
          rcnt <= rcnt + 6'd1;
        end
      end
      if (final_en) begin
        h_reg      <= h_sum;
        out_digest <= h_sum;
        out_valid  <= 1'b1;
      end
      if (done_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SHA256_BLKCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_count <= '0;
    end else if (done_hs) begin
      blk_count <= blk_count + 1'b1;
    end
  end
`endif

endmodule
